// File: rtl/rs_credit_ctrl.sv
// -----------------------------------------------------------------------------
// rs_credit_ctrl
//   Credit-based dispatch flow controller for the select/wakeup stage.
//   It tracks free entries in the ALU reservation station and the in-order
//   load/store reservation station. Each cycle it decides whether the current
//   dispatch group may be written into the stations and drives the stall.
//   Credits are consumed on accepted dispatch, returned on issue and restored
//   to full on a pipeline flush.
//
// Optional feature macro: RS_CREDIT_STATS_EN
//   Defined   : stall_cycles_o is a saturating 32-bit count of stall cycles.
//   Undefined : stall_cycles_o is tied to zero and no counter flops exist.
//
// Ports:
//   clk_i             in   1      clock
//   reset_i           in   1      synchronous active-high reset
//   dp_valid_i        in   1      dispatch group present this cycle
//   dp_req_alu_num_i  in   2      ALU entries requested (0..2, 3 illegal)
//   dp_req_mem_num_i  in   2      LDST entries requested (0..2, 3 illegal)
//   alu_issue_i       in   1      one ALU RS entry freed this cycle
//   mem_issue_i       in   1      one LDST RS entry freed this cycle
//   flush_i           in   1      misprediction flush, all RS entries dropped
//   dp_accept_o       out  1      dispatch group written into RS this cycle
//   stall_dp_o        out  1      dispatch must hold
//   alu_credit_o      out  CNT_W  current free ALU entries
//   mem_credit_o      out  CNT_W  current free LDST entries
//   err_o             out  1      sticky protocol error
//   stall_cycles_o    out  32     stall statistics (see macro above)
// -----------------------------------------------------------------------------
module rs_credit_ctrl #(
    parameter int ALU_ENT_NUM  = 8,
    parameter int LDST_ENT_NUM = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             dp_valid_i,
    input  logic [1:0]       dp_req_alu_num_i,
    input  logic [1:0]       dp_req_mem_num_i,
    input  logic             alu_issue_i,
    input  logic             mem_issue_i,
    input  logic             flush_i,
    output logic             dp_accept_o,
    output logic             stall_dp_o,
    output logic [CNT_W-1:0] alu_credit_o,
    output logic [CNT_W-1:0] mem_credit_o,
    output logic             err_o,
    output logic [31:0]      stall_cycles_o
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [CNT_W-1:0] ALU_MAX = CNT_W'(ALU_ENT_NUM);
    localparam logic [CNT_W-1:0] MEM_MAX = CNT_W'(LDST_ENT_NUM);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] alu_credit_q, alu_credit_d;
    logic [CNT_W-1:0] mem_credit_q, mem_credit_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] req_alu, req_mem;
    logic             illegal, short_credit, stall, accept;
    logic             alu_ovf, mem_ovf;

    // Next credit value. Accept never consumes more than is available, so only
    // the upper bound needs guarding; an issue into a full station saturates.
    function automatic logic [CNT_W-1:0] credit_next(
        input logic [CNT_W-1:0] credit,
        input logic [CNT_W-1:0] dec,
        input logic             inc,
        input logic [CNT_W-1:0] max
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, credit} - {1'b0, dec} + {{CNT_W{1'b0}}, inc};
        return (sum > {1'b0, max}) ? max : sum[CNT_W-1:0];
    endfunction

    // NOTE: every signal assigned in always_comb gets a default at the top of
    // the block so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_alu      = CNT_W'(dp_req_alu_num_i);
        req_mem      = CNT_W'(dp_req_mem_num_i);
        illegal      = dp_valid_i & ((dp_req_alu_num_i == 2'd3) | (dp_req_mem_num_i == 2'd3));
        // Credits freed by issue this cycle are deliberately not bypassed here.
        short_credit = (req_alu > alu_credit_q) | (req_mem > mem_credit_q);
        stall        = dp_valid_i & (short_credit | illegal | (state_q == ST_DRAIN) | flush_i);
        accept       = dp_valid_i & ~stall;

        alu_ovf      = alu_issue_i & (alu_credit_q == ALU_MAX);
        mem_ovf      = mem_issue_i & (mem_credit_q == MEM_MAX);

        state_d      = state_q;
        alu_credit_d = alu_credit_q;
        mem_credit_d = mem_credit_q;
        err_d        = err_q | illegal;

        if (flush_i) begin
            // Flush wins: stations empty, in-flight issues are meaningless.
            state_d      = ST_DRAIN;
            alu_credit_d = ALU_MAX;
            mem_credit_d = MEM_MAX;
        end else begin
            state_d      = ST_RUN;
            alu_credit_d = credit_next(alu_credit_q, accept ? req_alu : '0, alu_issue_i, ALU_MAX);
            mem_credit_d = credit_next(mem_credit_q, accept ? req_mem : '0, mem_issue_i, MEM_MAX);
            err_d        = err_q | illegal | alu_ovf | mem_ovf;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_RUN;
            alu_credit_q <= ALU_MAX;
            mem_credit_q <= MEM_MAX;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_credit_q <= alu_credit_d;
            mem_credit_q <= mem_credit_d;
            err_q        <= err_d;
        end
    end

`ifdef RS_CREDIT_STATS_EN
    logic [31:0] stall_cnt_q;

    // Saturating stall counter; survives flushes, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`else
    assign stall_cycles_o = '0;
`endif

    assign dp_accept_o  = accept;
    assign stall_dp_o   = stall;
    assign alu_credit_o = alu_credit_q;
    assign mem_credit_o = mem_credit_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_rs_credit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rs_credit_ctrl
//   Directed-vector bench with a scoreboard. The driver applies one vector per
//   cycle shortly after the rising edge and pushes the hand-computed expected
//   outputs for that cycle; the monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_rs_credit_ctrl;

    typedef struct {
        logic        chk;
        logic        acc;
        logic        stl;
        logic [3:0]  ac;
        logic [3:0]  mc;
        logic        er;
        logic [31:0] st;
        string       name;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        dp_valid_i = 1'b0;
    logic [1:0]  dp_req_alu_num_i = 2'd0;
    logic [1:0]  dp_req_mem_num_i = 2'd0;
    logic        alu_issue_i = 1'b0;
    logic        mem_issue_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        dp_accept_o;
    logic        stall_dp_o;
    logic [3:0]  alu_credit_o;
    logic [3:0]  mem_credit_o;
    logic        err_o;
    logic [31:0] stall_cycles_o;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned stall_count = 0;

    rs_credit_ctrl #(.ALU_ENT_NUM(8), .LDST_ENT_NUM(4), .CNT_W(4)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .dp_valid_i       (dp_valid_i),
        .dp_req_alu_num_i (dp_req_alu_num_i),
        .dp_req_mem_num_i (dp_req_mem_num_i),
        .alu_issue_i      (alu_issue_i),
        .mem_issue_i      (mem_issue_i),
        .flush_i          (flush_i),
        .dp_accept_o      (dp_accept_o),
        .stall_dp_o       (stall_dp_o),
        .alu_credit_o     (alu_credit_o),
        .mem_credit_o     (mem_credit_o),
        .err_o            (err_o),
        .stall_cycles_o   (stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // One cycle of stimulus plus the expected outputs for that same cycle.
    task automatic step(input logic chk, input logic v, input logic [1:0] ra, input logic [1:0] rm,
                        input logic ai, input logic mi, input logic fl,
                        input logic acc, input logic stl, input logic [3:0] ac,
                        input logic [3:0] mc, input logic er, input string name);
        exp_t e;
        @(posedge clk_i);
        #1;
        reset_i          = 1'b0;
        dp_valid_i       = v;
        dp_req_alu_num_i = ra;
        dp_req_mem_num_i = rm;
        alu_issue_i      = ai;
        mem_issue_i      = mi;
        flush_i          = fl;
        e.chk  = chk;
        e.acc  = acc;
        e.stl  = stl;
        e.ac   = ac;
        e.mc   = mc;
        e.er   = er;
`ifdef RS_CREDIT_STATS_EN
        e.st   = stall_count;
`else
        e.st   = 32'd0;
`endif
        e.name = name;
        sb_q.push_back(e);
        if (stl) stall_count++;
    endtask

    // Reset cycle with arbitrary other inputs; outputs are not checked here.
    task automatic do_reset(input logic v, input logic [1:0] ra, input logic ai);
        exp_t e;
        @(posedge clk_i);
        #1;
        reset_i          = 1'b1;
        dp_valid_i       = v;
        dp_req_alu_num_i = ra;
        dp_req_mem_num_i = 2'd0;
        alu_issue_i      = ai;
        mem_issue_i      = 1'b0;
        flush_i          = 1'b0;
        e.chk  = 1'b0;
        e.acc  = 1'b0;
        e.stl  = 1'b0;
        e.ac   = 4'd0;
        e.mc   = 4'd0;
        e.er   = 1'b0;
        e.st   = 32'd0;
        e.name = "reset";
        sb_q.push_back(e);
        stall_count = 0;
    endtask

    // Monitor: compares whatever the DUT presents against the queued vector.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    check({e.name, ".accept"}, 32'(dp_accept_o), 32'(e.acc));
                    check({e.name, ".stall"},  32'(stall_dp_o),  32'(e.stl));
                    check({e.name, ".alu_cr"}, 32'(alu_credit_o), 32'(e.ac));
                    check({e.name, ".mem_cr"}, 32'(mem_credit_o), 32'(e.mc));
                    check({e.name, ".err"},    32'(err_o),       32'(e.er));
                    check({e.name, ".stats"},  stall_cycles_o,   e.st);
                end
            end
        end
    end

    initial begin
        int budget;
        //        chk v  ra    rm    ai mi fl  acc stl ac     mc     er
        do_reset(1'b0, 2'd0, 1'b0);
        step(1, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 4'd8, 4'd4, 0, "rst_state");

        // ALU credit exhaustion: 8 -> 6 -> 4 -> 2 -> 0, then stall.
        step(1, 1, 2'd2, 2'd0, 0, 0, 0,  1, 0, 4'd8, 4'd4, 0, "alu_fill0");
        step(1, 1, 2'd2, 2'd0, 0, 0, 0,  1, 0, 4'd6, 4'd4, 0, "alu_fill1");
        step(1, 1, 2'd2, 2'd0, 0, 0, 0,  1, 0, 4'd4, 4'd4, 0, "alu_fill2");
        step(1, 1, 2'd2, 2'd0, 0, 0, 0,  1, 0, 4'd2, 4'd4, 0, "alu_fill3");
        step(1, 1, 2'd2, 2'd0, 0, 0, 0,  0, 1, 4'd0, 4'd4, 0, "alu_empty");
        step(1, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 4'd0, 4'd4, 0, "alu_hold0");

        // Issue credit not bypassed into the same cycle's decision.
        step(1, 1, 2'd1, 2'd0, 1, 0, 0,  0, 1, 4'd0, 4'd4, 0, "no_bypass");
        step(1, 1, 2'd1, 2'd0, 0, 0, 0,  1, 0, 4'd1, 4'd4, 0, "after_iss");
        step(1, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 4'd0, 4'd4, 0, "after_acc");

        // Partial fit: ALU fits, mem short -> nothing consumed.
        do_reset(1'b0, 2'd0, 1'b0);
        step(1, 1, 2'd0, 2'd2, 0, 0, 0,  1, 0, 4'd8, 4'd4, 0, "mem_take2");
        step(1, 1, 2'd0, 2'd1, 0, 0, 0,  1, 0, 4'd8, 4'd2, 0, "mem_take1");
        step(1, 1, 2'd1, 2'd2, 0, 0, 0,  0, 1, 4'd8, 4'd1, 0, "partial");
        step(1, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 4'd8, 4'd1, 0, "partial_nc");

        // Accept and issue together, both applied.
        step(1, 1, 2'd2, 2'd0, 0, 1, 0,  1, 0, 4'd8, 4'd1, 0, "acc_iss");
        step(1, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 4'd6, 4'd2, 0, "acc_iss_r");

        // Flush with a valid request, then DRAIN stall, then accept.
        step(1, 1, 2'd2, 2'd2, 0, 0, 0,  1, 0, 4'd6, 4'd2, 0, "pre_fl0");
        step(1, 1, 2'd1, 2'd0, 0, 0, 0,  1, 0, 4'd4, 4'd0, 0, "pre_fl1");
        step(1, 1, 2'd1, 2'd0, 0, 0, 1,  0, 1, 4'd3, 4'd0, 0, "flush");
        step(1, 1, 2'd1, 2'd0, 0, 0, 0,  0, 1, 4'd8, 4'd4, 0, "drain");
        step(1, 1, 2'd1, 2'd0, 0, 0, 0,  1, 0, 4'd8, 4'd4, 0, "post_drn");
        step(1, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 4'd7, 4'd4, 0, "post_drn_r");

        // Issues during flush are ignored (mem is full: no overflow error).
        step(1, 0, 2'd0, 2'd0, 1, 1, 1,  0, 0, 4'd7, 4'd4, 0, "fl_issue");
        step(1, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 4'd8, 4'd4, 0, "fl_iss_r");

        // Overflow: saturate and sticky error.
        step(1, 0, 2'd0, 2'd0, 1, 0, 0,  0, 0, 4'd8, 4'd4, 0, "ovf");
        step(1, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 4'd8, 4'd4, 1, "ovf_r");
        step(1, 1, 2'd3, 2'd0, 0, 0, 0,  0, 1, 4'd8, 4'd4, 1, "illegal_a");
        step(1, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 4'd8, 4'd4, 1, "err_stick");

        // Illegal request from clean state sets the error.
        do_reset(1'b0, 2'd0, 1'b0);
        step(1, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 4'd8, 4'd4, 0, "err_clr");
        step(1, 1, 2'd0, 2'd3, 0, 0, 0,  0, 1, 4'd8, 4'd4, 0, "illegal_m");
        step(1, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 4'd8, 4'd4, 1, "illegal_r");

        // Reset mid-operation wins over a concurrent request and issue.
        step(1, 1, 2'd2, 2'd0, 0, 0, 0,  1, 0, 4'd8, 4'd4, 1, "pre_rst");
        do_reset(1'b1, 2'd2, 1'b1);
        step(1, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 4'd8, 4'd4, 0, "mid_rst");

        // Five forced stall cycles feed the statistics counter.
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 2'd3, 2'd0, 0, 0, 0,  0, 1, 4'd8, 4'd4, (i != 0), "stat_stall");
        end
        step(1, 0, 2'd0, 2'd0, 0, 0, 0,  0, 0, 4'd8, 4'd4, 1, "stat_total");

        @(posedge clk_i);
        #1;
        dp_valid_i = 1'b0;
        budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge clk_i);
            budget--;
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
